// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcodes, instruction
// field positions, FSM state encoding and opcode classification.
package cpu_pkg;

   localparam logic [3:0] OP_LDI  = 4'b1000;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 9;
   localparam int RS_MSB  = 8;
   localparam int RS_LSB  = 6;
   localparam int RT_MSB  = 5;
   localparam int RT_LSB  = 3;
   localparam int IMM_MSB = 5;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } seq_state_t;

   typedef enum logic [1:0] {
      CLS_ALU  = 2'd0,
      CLS_LDI  = 2'd1,
      CLS_HALT = 2'd2,
      CLS_NOP  = 2'd3
   } op_class_t;

   // Opcodes 0-7 go to the ALU; the upper half holds LDI, HALT and NOPs.
   function automatic op_class_t op_class(input logic [3:0] op);
      if (!op[3])
         return CLS_ALU;
      else if (op == OP_LDI)
         return CLS_LDI;
      else if (op == OP_HALT)
         return CLS_HALT;
      else
         return CLS_NOP;
   endfunction

endpackage

// File: rtl/cpu_seq_ctrl_regfile.sv
// 8x16 register file: two combinational read ports, one synchronous write
// port, asynchronous clear of all entries.
module regfile8x16
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [2:0]  waddr,
   input  logic [15:0] wdata,
   input  logic [2:0]  raddr_a,
   input  logic [2:0]  raddr_b,
   output logic [15:0] rdata_a,
   output logic [15:0] rdata_b
);

   logic [7:0][15:0] regs;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         regs <= '0;
      else if (we)
         regs[waddr] <= wdata;
   end

   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Start/halt controlled FETCH/DECODE/EXEC/WB sequencer owning PC, IR, result
// register and register file. Optional retired-instruction counter: CPU_SEQ_PERF_EN.
module cpu_seq_ctrl
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] instr,
   input  logic [15:0] alu_result,
   output logic [15:0] pc_addr,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [2:0]  alu_ctrl,
   output logic        busy,
   output logic        halted,
   output logic        wb_valid,
   output logic [2:0]  wb_addr,
   output logic [15:0] wb_data,
   output logic [15:0] instr_count
);

   seq_state_t  state;
   logic [15:0] pc;
   logic [15:0] ir;
   logic [15:0] res;
   op_class_t   cls;
   logic        start_ok;
   logic        wr_en;
   logic        opnd_en;
   logic [15:0] rd_a;
   logic [15:0] rd_b;
   logic [15:0] imm_zx;

   assign cls      = op_class(ir[OP_MSB:OP_LSB]);
   assign start_ok = start && (state == IDLE || state == HALT);
   assign wr_en    = (state == WB) && (cls == CLS_ALU || cls == CLS_LDI);
   assign opnd_en  = (state == DECODE) || (state == EXEC);
   assign imm_zx   = {10'd0, ir[IMM_MSB:IMM_LSB]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pc    <= RESET_PC;
         ir    <= '0;
         res   <= '0;
      end else begin
         case (state)
            IDLE, HALT: begin
               if (start_ok) begin
                  state <= FETCH;
                  pc    <= RESET_PC;
               end
            end
            FETCH: begin
               ir    <= instr;
               state <= DECODE;
            end
            // HALT leaves the PC pointing at the HALT word itself.
            DECODE: state <= (cls == CLS_HALT) ? HALT : EXEC;
            EXEC: begin
               res   <= (cls == CLS_LDI) ? imm_zx : alu_result;
               state <= WB;
            end
            WB: begin
               pc    <= pc + 16'd1;
               state <= FETCH;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Writes land at the end of WB, so the next DECODE already sees them.
   regfile8x16 u_rf (
      .clk     (clk),
      .reset   (reset),
      .we      (wr_en),
      .waddr   (ir[RD_MSB:RD_LSB]),
      .wdata   (res),
      .raddr_a (ir[RS_MSB:RS_LSB]),
      .raddr_b (ir[RT_MSB:RT_LSB]),
      .rdata_a (rd_a),
      .rdata_b (rd_b)
   );

   assign pc_addr  = pc;
   assign alu_a    = opnd_en ? rd_a : 16'h0000;
   assign alu_b    = opnd_en ? rd_b : 16'h0000;
   assign alu_ctrl = ir[OP_MSB-1:OP_LSB];
   assign busy     = (state == FETCH) || (state == DECODE) || (state == EXEC) || (state == WB);
   assign halted   = (state == HALT);
   assign wb_valid = wr_en;
   assign wb_addr  = ir[RD_MSB:RD_LSB];
   assign wb_data  = res;

`ifdef CPU_SEQ_PERF_EN
   logic [15:0] retired;

   // Every WB retires an instruction, NOPs included.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         retired <= '0;
      else if (start_ok)
         retired <= '0;
      else if (state == WB)
         retired <= retired + 16'd1;
   end

   assign instr_count = retired;
`else
   assign instr_count = 16'h0000;
`endif

endmodule
